// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 inverse cipher: one round per cycle. Round keys are fetched
// from an external combinational key store via rk_addr/rk_data.
module aes_inv_cipher_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] inmatrix,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] outmatrix,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_e;

  // Inverse S-box, entry b at bits [2047-8b -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] data_q, data_d;
  logic [127:0] sub_key;

  function automatic logic [7:0] inv_sbox_byte(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant; enough for the {0e,0b,0d,09} coefficients.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] res;
    int row, col, src;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      row = k % 4;
      col = k / 4;
      src = row + 4 * ((col - row + 4) % 4);
      res[127 - 8 * k -: 8] = inv_sbox_byte(s[127 - 8 * src -: 8]);
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a [4];
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127 - 8 * (4 * c + i) -: 8];
      for (int i = 0; i < 4; i++)
        res[127 - 8 * (4 * c + i) -: 8] = gmul(a[i], 4'hE) ^ gmul(a[(i + 1) % 4], 4'hB) ^
                                           gmul(a[(i + 2) % 4], 4'hD) ^ gmul(a[(i + 3) % 4], 4'h9);
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    data_d  = data_q;
    sub_key = inv_shift_sub(data_q) ^ rk_data;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = inmatrix ^ rk_data;
          round_d = 4'd9;
          state_d = ROUND;
        end
      end
      ROUND: begin
        // The last round (key 0) skips InvMixColumns.
        if (round_q == 4'd0) begin
          data_d  = sub_key;
          state_d = DONE;
        end else begin
          data_d  = inv_mix(sub_key);
          round_d = round_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    rk_addr   = 4'd0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        rk_addr  = 4'd10;
      end
      ROUND: begin
        busy    = 1'b1;
        rk_addr = round_q;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b1;
        rk_addr  = 4'd10;
      end
    endcase
  end

  assign outmatrix = data_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Self-checking bench for aes_inv_cipher_ctrl: transaction-level AES model with
// tables derived from GF(2^8) arithmetic, per-cycle compare, randomized stimulus.
module tb_aes_inv_cipher_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] inmatrix = '0;
  logic [127:0] rk_data, outmatrix;
  logic         in_ready, out_valid, busy;
  logic [3:0]   rk_addr;
  logic         noise_en = 1'b0;
  logic [127:0] noise = '0;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] round_key [11];

  // Transaction model: idle, or busy with a count of edges since accept.
  logic         m_active = 1'b0;
  int           m_cnt = 0;
  logic [127:0] m_result = '0;
  int           cyc = 0;
  int           last_hs = -100;
  int           last_gap = 0;
  int           n_done = 0;

  always #5 clk = ~clk;

  aes_inv_cipher_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inmatrix  (inmatrix),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outmatrix (outmatrix),
    .busy      (busy)
  );

  assign rk_data = ((rk_addr <= 4'd10) ? round_key[rk_addr] : 128'h0) ^ (noise_en ? noise : 128'h0);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = (x << n) | (x >> (8 - n));
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[a] = s;
      inv_sbox[s] = 8'(a);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) round_key[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Textbook AES-128 decryption on a 4x4 byte array (index = row + 4*col).
  function automatic logic [127:0] inv_cipher(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int k = 0; k < 16; k++) s[k] = ct[127 - 8 * k -: 8] ^ round_key[10][127 - 8 * k -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          t[row + 4 * col] = s[row + 4 * ((col - row + 4) % 4)];
      for (int k = 0; k < 16; k++) t[k] = inv_sbox[t[k]] ^ round_key[r][127 - 8 * k -: 8];
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 4; i++)
          s[4 * c + i] = (r == 0) ? t[4 * c + i] :
                         gf_mul(t[4 * c + i], 8'h0e) ^ gf_mul(t[4 * c + (i + 1) % 4], 8'h0b) ^
                         gf_mul(t[4 * c + (i + 2) % 4], 8'h0d) ^ gf_mul(t[4 * c + (i + 3) % 4], 8'h09);
    end
    for (int k = 0; k < 16; k++) res[127 - 8 * k -: 8] = s[k];
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] ct);
    in_valid = 1'b1;
    inmatrix = ct;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitOutValid(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) checkOutput("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic handshake();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_cnt    <= 0;
        m_result <= inv_cipher(inmatrix);
        last_gap <= cyc - last_hs;
      end
    end else if (m_cnt == 10) begin
      if (out_ready) begin
        m_active <= 1'b0;
        last_hs  <= cyc;
        n_done   <= n_done + 1;
      end
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    checkOutput("in_ready", in_ready, !m_active);
    checkOutput("busy", busy, m_active);
    checkOutput("out_valid", out_valid, m_active && m_cnt == 10);
    checkOutput("rk_addr", rk_addr, !m_active ? 4'd10 : (m_cnt < 10 ? 4'(9 - m_cnt) : 4'd0));
    if (m_active && m_cnt == 10) checkOutput("outmatrix", outmatrix, m_result);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int done_before;
    build_tables();
    expand_key(C1_KEY);
    checkOutput("pin_sbox00", sbox[0], 8'h63);
    checkOutput("pin_invsbox00", inv_sbox[0], 8'h52);
    checkOutput("pin_rk10", round_key[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    checkOutput("pin_model_c1", inv_cipher(C1_CT), C1_PT);

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_rk_addr", rk_addr, 4'd10);
    checkOutput("rst_outmatrix", outmatrix, 128'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known answer with back-pressure and key-store noise while finished.
    applyStimulus(C1_CT);
    waitOutValid(lat);
    checkOutput("kat_latency", lat, 10);
    checkOutput("kat_pt", outmatrix, C1_PT);
    noise_en = 1'b1;
    repeat (5) begin
      noise = rand128();
      @(posedge clk);
      #1;
      checkOutput("bp_valid", out_valid, 1'b1);
      checkOutput("bp_pt", outmatrix, C1_PT);
    end
    noise_en = 1'b0;
    handshake();
    checkOutput("bp_idle", in_ready, 1'b1);

    // Random in_valid / inmatrix while busy must be ignored.
    applyStimulus(C1_CT);
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      inmatrix = rand128();
      @(posedge clk);
      #1;
      checkOutput("ignore_ready", in_ready, 1'b0);
      if (i >= 9) checkOutput("ignore_pt", outmatrix, C1_PT);
    end
    handshake();

    // Asynchronous reset with rk_addr at 4.
    applyStimulus(C1_CT);
    repeat (5) @(posedge clk);
    #3;
    checkOutput("pre_reset_rk", rk_addr, 4'd4);
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", out_valid, 1'b0);
    checkOutput("async_busy", busy, 1'b0);
    checkOutput("async_rk_addr", rk_addr, 4'd10);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(C1_CT);
    waitOutValid(lat);
    checkOutput("post_reset_latency", lat, 10);
    checkOutput("post_reset_pt", outmatrix, C1_PT);
    handshake();

    // Back-to-back with in_valid and out_ready held high.
    done_before = n_done;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      inmatrix = rand128();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("b2b_drain", in_ready, 1'b1);
    checkOutput("b2b_blocks", n_done - done_before >= 10, 1'b1);
    checkOutput("b2b_gap", last_gap, 1);

    // Fully random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      inmatrix  = rand128();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rand_drain", in_ready, 1'b1);
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
AES_INV_CIPHER_CTRL -- requirements
Module: aes_inv_cipher_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port `clk`, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-003 Port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 Port `in_valid`, input, 1 bit: a ciphertext block is offered.
REQ-005 Port `in_ready`, output, 1 bit: the block can accept a ciphertext.
REQ-006 Port `inmatrix`, input, 128 bits: ciphertext state.
  - Byte k occupies bits [127-8k:120-8k].
  - Layout is column-major: byte k is row k%4, column k/4.
REQ-007 Port `rk_addr`, output, 4 bits: index of the requested round key, 0..10.
REQ-008 Port `rk_data`, input, 128 bits: round key for `rk_addr`.
  - The external key store returns it combinationally, in the same cycle.
  - Byte layout is as in REQ-006.
REQ-009 Port `out_valid`, output, 1 bit: `outmatrix` holds a finished plaintext.
REQ-010 Port `out_ready`, input, 1 bit: the consumer accepts the plaintext.
REQ-011 Port `outmatrix`, output, 128 bits: plaintext state, byte layout as in REQ-006.
REQ-012 Port `busy`, output, 1 bit: high in the ROUND state and in the DONE state.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, ROUND and DONE.
REQ-014 In IDLE:
  - `in_ready`=1 and `rk_addr`=10.
  - Accept occurs when `in_valid`=1: load state <= `inmatrix` XOR `rk_data`, round counter r <= 9, go to ROUND.
REQ-015 In ROUND, each cycle:
  - `rk_addr`=r.
  - state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), `rk_data`)) when r>=1.
  - Then r decrements.
REQ-016 When r=0, the ROUND cycle SHALL omit InvMixColumns: state <= InvSubBytes(InvShiftRows(state)) XOR `rk_data`, then go to DONE.
REQ-017 InvShiftRows SHALL rotate row n right by n byte positions, n=0..3.
  - For n=1: out byte 1 = in byte 13, out byte 5 = in byte 1, and so on.
REQ-018 InvSubBytes SHALL apply the FIPS-197 inverse S-box to all 16 bytes.
REQ-019 InvMixColumns SHALL multiply each column by {0e,0b,0d,09} in GF(2^8), modulo x^8+x^4+x^3+x+1.
REQ-020 In DONE:
  - `out_valid`=1 and `outmatrix`=state.
  - Both hold stable until `out_ready`=1.
  - On the handshake, go to IDLE.
REQ-021 Latency SHALL be fixed: accept at edge T gives `out_valid`=1 after edge T+10, i.e. 10 ROUND cycles.
REQ-022 `in_ready` SHALL be 0 in ROUND and DONE; `in_valid` in those states SHALL be ignored and SHALL NOT disturb state.
REQ-023 The next accept SHALL occur no earlier than the cycle after the output handshake; there is no overlap of blocks.
REQ-024 `rk_addr` SHALL be 0 in DONE.
REQ-025 `outmatrix` SHALL show the internal state register in every state.
  - Only its DONE value is meaningful.
REQ-026 `rk_data` is sampled only in the IDLE accept cycle and in ROUND cycles.
  - Changes at any other time SHALL have no effect.

Reset
REQ-027 On `rst_n`=0, at any time including mid-ROUND or in DONE, the block SHALL immediately apply these values:
  - FSM=IDLE, r=0, state=0.
  - `out_valid`=0, `busy`=0, `in_ready`=1, `rk_addr`=10.
REQ-028 A block in flight when reset is asserted SHALL be discarded; no `out_valid` pulse is produced for it.
REQ-029 After `rst_n` deasserts, the first rising edge with `in_valid`=1 SHALL accept a block.

Verification
REQ-030 FIPS-197 C.1 known answer:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (bench key store); ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required response: `outmatrix`=00112233445566778899aabbccddeeff with `out_valid` 10 cycles after accept.
REQ-031 Back-pressure:
  - Stimulus: vector of REQ-030 with `out_ready` held 0 for 5 cycles after `out_valid`.
  - Required response: `out_valid` and `outmatrix` stable all 5 cycles; IDLE one cycle after `out_ready`=1.
REQ-032 Busy ignore:
  - Stimulus: toggle `in_valid` and `inmatrix` randomly during ROUND and DONE.
  - Required response: `in_ready`=0 throughout; result equals the REQ-030 plaintext.
REQ-033 Reset mid-round:
  - Stimulus: assert `rst_n`=0 at ROUND r=4.
  - Required response: `out_valid`=0 and `busy`=0 without waiting for a clock edge; a fresh REQ-030 run then passes.
REQ-034 `rk_addr` sequence:
  - Stimulus: any single accepted block.
  - Required response: `rk_addr` = 10 at accept, then 9, 8, ..., 0 on consecutive cycles, then 0 in DONE.
REQ-035 Back-to-back:
  - Stimulus: two blocks, `in_valid` held high, `out_ready` held high.
  - Required response: second accept one cycle after the first handshake; both outputs correct against the reference model.
